jstk2_spi_responder: RTL and testbench

JSTK2_SPI_RESPONDER -- requirements
Module: jstk2_spi_responder

---
 rtl/jstk2_pkg.sv | 56 +++++
 rtl/jstk2_spi_responder_if.sv | 11 +
 rtl/jstk2_spi_responder_spi_sync.sv | 43 ++++
 rtl/jstk2_spi_responder.sv | 143 ++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/jstk2_pkg.sv
// Shared definitions for the JSTK2 joystick SPI responder and its master:
// state encodings, command/index constants and the response byte map.
package jstk2_pkg;

    localparam int unsigned AXIS_W = 10;
    localparam int unsigned JOY_W  = 11;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RGB_W  = 24;
    localparam int unsigned IDX_W  = 3;

    localparam logic [AXIS_W-1:0] CENTRE_DEFAULT = 10'h200;

    localparam logic [BYTE_W-1:0] CMD_LED_OFF = 8'h80;
    localparam logic [BYTE_W-1:0] CMD_LED_ON  = 8'h81;
    localparam logic [BYTE_W-1:0] CMD_LED_RGB = 8'h84;

    localparam logic [IDX_W-1:0] IDX_BUTTONS = 3'd4;
    localparam logic [IDX_W-1:0] IDX_POSX    = 3'd5;
    localparam logic [IDX_W-1:0] IDX_POSY    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_END   = 2'd3
    } state_t;

    typedef struct packed {
        logic [AXIS_W-1:0] x;
        logic [AXIS_W-1:0] y;
        logic [BYTE_W-1:0] buttons;
    } jstk_snap_t;

    // Opposing directions pressed together cancel out to the centre value.
    function automatic logic [AXIS_W-1:0] axis_value(input logic pos, input logic neg,
                                                     input logic [AXIS_W-1:0] centre);
        if (pos && !neg)      return 10'h3FF;
        else if (neg && !pos) return 10'h000;
        else                  return centre;
    endfunction

    function automatic logic [BYTE_W-1:0] resp_byte(input logic [IDX_W-1:0] idx,
                                                    input jstk_snap_t s);
        case (idx)
            3'd0:        return s.x[7:0];
            3'd1:        return {6'b0, s.x[9:8]};
            3'd2:        return s.y[7:0];
            3'd3:        return {6'b0, s.y[9:8]};
            IDX_BUTTONS: return s.buttons;
            IDX_POSX:    return s.x[9:2];
            IDX_POSY:    return s.y[9:2];
            default:     return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// SPI bus between the joystick master and the responder.
interface jstk2_spi_responder_if;
    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/jstk2_spi_responder_spi_sync.sv
// Two-flop synchronizers for sclk/ss_n/mosi plus sclk edge detection.
module spi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic ss_n_sync,
    output logic mosi_sync,
    output logic sclk_rise_c,
    output logic sclk_fall_c,
    output logic ready
);
    logic [1:0] sclk_ff;
    logic [1:0] ss_ff;
    logic [1:0] mosi_ff;
    logic       sclk_prev;
    logic [1:0] warm;

    // warm marks when the synchronizer outputs reflect real pin values, not reset fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff   <= 2'b00;
            ss_ff     <= 2'b11;
            mosi_ff   <= 2'b00;
            sclk_prev <= 1'b0;
            warm      <= 2'b00;
        end else begin
            sclk_ff   <= {sclk_ff[0], sclk};
            ss_ff     <= {ss_ff[0], ss_n};
            mosi_ff   <= {mosi_ff[0], mosi};
            sclk_prev <= sclk_ff[1];
            warm      <= {warm[0], 1'b1};
        end
    end

    assign ss_n_sync   = ss_ff[1];
    assign mosi_sync   = mosi_ff[1];
    assign sclk_rise_c = sclk_ff[1] & ~sclk_prev;
    assign sclk_fall_c = ~sclk_ff[1] & sclk_prev;
    assign ready       = warm[1];

endmodule

// File: rtl/jstk2_spi_responder.sv
// JSTK2-compatible SPI slave: reports joystick axes/buttons and accepts LED commands.
module jstk2_spi_responder
    import jstk2_pkg::*;
#(
    parameter logic [AXIS_W-1:0] CENTRE = CENTRE_DEFAULT
) (
    input  logic                 clk_peripheral,
    input  logic                 reset_n,
    input  logic [JOY_W-1:0]     joystick,
    jstk2_spi_responder_if.slave spi,
    output logic                 led_en,
    output logic [RGB_W-1:0]     led_rgb,
    output logic                 frame_done
);
    logic ss_n_sync, mosi_sync, sclk_rise_c, sclk_fall_c, sync_ready;

    spi_sync u_sync (
        .clk         (clk_peripheral),
        .rst_n       (reset_n),
        .sclk        (spi.sclk),
        .ss_n        (spi.ss_n),
        .mosi        (spi.mosi),
        .ss_n_sync   (ss_n_sync),
        .mosi_sync   (mosi_sync),
        .sclk_rise_c (sclk_rise_c),
        .sclk_fall_c (sclk_fall_c),
        .ready       (sync_ready)
    );

    state_t            state;
    jstk_snap_t        snap;
    jstk_snap_t        snap_c;
    logic [IDX_W-1:0]  byte_idx;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] rx_shift;
    logic [BYTE_W-1:0] tx_shift;
    logic [BYTE_W-1:0] cmd;
    logic [RGB_W-1:0]  rgb_cand;
    logic              armed;
    logic              miso_q;
    logic              miso_oe_q;
    logic [BYTE_W-1:0] load_byte_c;
    logic [BYTE_W-1:0] next_byte_c;
    logic [BYTE_W-1:0] rx_byte_c;
    logic              unused_joy;

    always_comb begin
        snap_c.x       = axis_value(joystick[0], joystick[1], CENTRE);
        snap_c.y       = axis_value(joystick[3], joystick[2], CENTRE);
        snap_c.buttons = {6'b0, joystick[5], joystick[7]};
    end

    assign load_byte_c = resp_byte(3'd0, snap_c);
    assign next_byte_c = resp_byte(byte_idx, snap);
    assign rx_byte_c   = {rx_shift[6:0], mosi_sync};
    assign unused_joy  = ^{joystick[10:8], joystick[6], joystick[4]};

    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;

    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            snap       <= '0;
            byte_idx   <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            cmd        <= '0;
            rgb_cand   <= '0;
            armed      <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            led_en     <= 1'b0;
            led_rgb    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A frame only starts on a fall seen after ss_n was observed high post-reset.
            armed <= (state != ST_LOAD) && (armed || (sync_ready && ss_n_sync));

            unique case (state)
                ST_IDLE: begin
                    if (armed && !ss_n_sync) begin
                        state     <= ST_LOAD;
                        miso_oe_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    snap     <= snap_c;
                    byte_idx <= '0;
                    bit_cnt  <= '0;
                    cmd      <= '0;
                    miso_q   <= load_byte_c[7];
                    tx_shift <= {load_byte_c[6:0], 1'b0};
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (ss_n_sync) begin
                        state      <= ST_END;
                        miso_q     <= 1'b0;
                        miso_oe_q  <= 1'b0;
                        frame_done <= 1'b1;
                        // byte_idx counts fully received bytes; partial bytes never advance it.
                        if (cmd == CMD_LED_OFF && byte_idx >= 3'd1) begin
                            led_en <= 1'b0;
                        end else if (cmd == CMD_LED_ON && byte_idx >= 3'd1) begin
                            led_en <= 1'b1;
                        end else if (cmd == CMD_LED_RGB && byte_idx >= 3'd4) begin
                            led_en  <= 1'b1;
                            led_rgb <= rgb_cand;
                        end
                    end else if (sclk_rise_c) begin
                        rx_shift <= rx_byte_c;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (byte_idx)
                                3'd0:    cmd             <= rx_byte_c;
                                3'd1:    rgb_cand[23:16] <= rx_byte_c;
                                3'd2:    rgb_cand[15:8]  <= rx_byte_c;
                                3'd3:    rgb_cand[7:0]   <= rx_byte_c;
                                default: ;
                            endcase
                            if (byte_idx != 3'd7) byte_idx <= byte_idx + 3'd1;
                        end
                    end else if (sclk_fall_c) begin
                        if (bit_cnt == 3'd0) begin
                            miso_q   <= next_byte_c[7];
                            tx_shift <= {next_byte_c[6:0], 1'b0};
                        end else begin
                            miso_q   <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_END: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Randomized and directed bench for jstk2_spi_responder against a spec-level model.
module tb_jstk2_spi_responder;

    localparam int HALF = 8;

    logic        clk;
    logic        reset_n;
    logic [10:0] joy;
    logic        led_en;
    logic [23:0] led_rgb;
    logic        frame_done;

    jstk2_spi_responder_if spi_bus ();

    jstk2_spi_responder dut (
        .clk_peripheral (clk),
        .reset_n        (reset_n),
        .joystick       (joy),
        .spi            (spi_bus.slave),
        .led_en         (led_en),
        .led_rgb        (led_rgb),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fd_count = 0;

    logic [7:0]  mo [0:9];
    logic [7:0]  mi [0:9];
    logic        m_led_en;
    logic [23:0] m_led_rgb;
    logic [10:0] joy_snap;

    always @(negedge clk) if (frame_done) fd_count++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected response byte from the joystick word, using plain arithmetic.
    function automatic int exp_byte(input logic [10:0] j, input int idx);
        int x, y, btn;
        x = (j[0] && !j[1]) ? 1023 : (j[1] && !j[0]) ? 0 : 512;
        y = (j[3] && !j[2]) ? 1023 : (j[2] && !j[3]) ? 0 : 512;
        btn = (j[5] ? 2 : 0) + (j[7] ? 1 : 0);
        case (idx)
            0: return x % 256;
            1: return x / 256;
            2: return y % 256;
            3: return y / 256;
            4: return btn;
            5: return x / 4;
            6: return y / 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_apply(input int nfull);
        if (nfull >= 1 && mo[0] == 8'h80) m_led_en = 1'b0;
        else if (nfull >= 1 && mo[0] == 8'h81) m_led_en = 1'b1;
        else if (nfull >= 4 && mo[0] == 8'h84) begin
            m_led_en  = 1'b1;
            m_led_rgb = {mo[1], mo[2], mo[3]};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"}, 32'(spi_bus.miso), 32'h0);
        check_eq({tag, "_miso_oe"}, 32'(spi_bus.miso_oe), 32'h0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        check_eq({tag, "_led_en"}, 32'(led_en), 32'h0);
        check_eq({tag, "_led_rgb"}, 32'(led_rgb), 32'h0);
    endtask

    // One SPI mode-0 frame; abort_bit >= 0 pulses reset at that bit instead of finishing.
    task automatic spi_frame(input int nfull, input int extra, input int abort_bit,
                             input bit change_joy, input int change_bit, input logic [10:0] joy_new);
        int total;
        int fd_start;
        total    = nfull * 8 + extra;
        fd_start = fd_count;
        joy_snap = joy;
        @(negedge clk);
        spi_bus.ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < total; b++) begin
            if (b == abort_bit) begin
                reset_n = 1'b0;
                repeat (2) @(negedge clk);
                check_reset_outputs("abort");
                m_led_en  = 1'b0;
                m_led_rgb = 24'h0;
                reset_n = 1'b1;
                spi_bus.sclk = 1'b0;
                spi_bus.ss_n = 1'b1;
                repeat (12) @(negedge clk);
                check_eq("abort_no_frame_done", 32'(fd_count - fd_start), 32'd0);
                return;
            end
            spi_bus.mosi = mo[b / 8][7 - (b % 8)];
            repeat (HALF) @(negedge clk);
            mi[b / 8][7 - (b % 8)] = spi_bus.miso;
            if (b == 0) check_eq("miso_oe_in_frame", 32'(spi_bus.miso_oe), 32'h1);
            spi_bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_bus.sclk = 1'b0;
            if (change_joy && b == change_bit) joy = joy_new;
        end
        repeat (HALF) @(negedge clk);
        spi_bus.ss_n = 1'b1;
        spi_bus.mosi = 1'b0;
        repeat (12) @(negedge clk);
        model_apply(nfull);
        check_eq("frame_done_pulses", 32'(fd_count - fd_start), 32'd1);
        check_eq("miso_oe_after", 32'(spi_bus.miso_oe), 32'h0);
        check_eq("miso_after", 32'(spi_bus.miso), 32'h0);
        check_eq("led_en", 32'(led_en), 32'(m_led_en));
        check_eq("led_rgb", 32'(led_rgb), 32'(m_led_rgb));
        for (int i = 0; i < nfull; i++)
            check_eq($sformatf("resp_byte%0d", i), 32'(mi[i]), 32'(exp_byte(joy_snap, i)));
    endtask

    task automatic set_cmd(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        mo[0] = b0; mo[1] = b1; mo[2] = b2; mo[3] = b3;
        for (int i = 4; i < 10; i++) mo[i] = 8'h00;
    endtask

    initial begin
        reset_n      = 1'b0;
        joy          = 11'h0;
        spi_bus.sclk = 1'b0;
        spi_bus.ss_n = 1'b1;
        spi_bus.mosi = 1'b0;
        m_led_en     = 1'b0;
        m_led_rgb    = 24'h0;
        for (int i = 0; i < 10; i++) begin mo[i] = 8'h00; mi[i] = 8'h00; end
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // Idle joystick, plain 7-byte read.
        set_cmd(8'h00, 8'h00, 8'h00, 8'h00);
        spi_frame(7, 0, -1, 1'b0, 0, 11'h0);

        // Right, up, trigger and stick button.
        joy = 11'h0A9;
        spi_frame(7, 0, -1, 1'b0, 0, 11'h0);

        // Full RGB command, then LED off keeps the colour.
        set_cmd(8'h84, 8'h12, 8'h34, 8'h56);
        spi_frame(5, 0, -1, 1'b0, 0, 11'h0);
        check_eq("rgb_cmd_rgb", 32'(led_rgb), 32'h123456);
        check_eq("rgb_cmd_en", 32'(led_en), 32'h1);
        set_cmd(8'h80, 8'h00, 8'h00, 8'h00);
        spi_frame(1, 0, -1, 1'b0, 0, 11'h0);
        check_eq("off_cmd_en", 32'(led_en), 32'h0);
        check_eq("off_cmd_rgb", 32'(led_rgb), 32'h123456);

        // RGB command cut short 5 bits into the 4th byte.
        set_cmd(8'h84, 8'hAA, 8'hBB, 8'hCC);
        spi_frame(3, 5, -1, 1'b0, 0, 11'h0);
        check_eq("partial_rgb", 32'(led_rgb), 32'h123456);
        check_eq("partial_en", 32'(led_en), 32'h0);

        // Joystick moves right during byte 2; this frame keeps the centre.
        joy = 11'h000;
        set_cmd(8'h00, 8'h00, 8'h00, 8'h00);
        spi_frame(7, 0, -1, 1'b1, 18, 11'h001);
        check_eq("snap_x_lo", 32'(mi[0]), 32'h00);
        check_eq("snap_x_hi", 32'(mi[1]), 32'h02);
        spi_frame(7, 0, -1, 1'b0, 0, 11'h0);
        check_eq("next_x_lo", 32'(mi[0]), 32'hFF);
        check_eq("next_x_hi", 32'(mi[1]), 32'h03);

        // Reset during byte 1 of an RGB frame, then a clean read.
        set_cmd(8'h81, 8'h00, 8'h00, 8'h00);
        spi_frame(1, 0, -1, 1'b0, 0, 11'h0);
        set_cmd(8'h84, 8'h11, 8'h22, 8'h33);
        spi_frame(5, 0, 11, 1'b0, 0, 11'h0);
        joy = 11'h006;
        set_cmd(8'h00, 8'h00, 8'h00, 8'h00);
        spi_frame(7, 0, -1, 1'b0, 0, 11'h0);

        // Randomized frames: commands, lengths, partial bytes, mid-frame joystick moves.
        for (int f = 0; f < 20; f++) begin
            int nfull, extra, sel;
            joy = 11'($urandom);
            sel = int'($urandom_range(0, 3));
            for (int i = 0; i < 10; i++) mo[i] = 8'($urandom);
            case (sel)
                0: mo[0] = 8'h80;
                1: mo[0] = 8'h81;
                2: mo[0] = 8'h84;
                default: ;
            endcase
            nfull = int'($urandom_range(0, 8));
            extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
            spi_frame(nfull, extra, -1, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), 11'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
